// File: rtl/dit_reorder.sv
// Ping-pong bit-reversal reorder buffer ahead of the DIT FFT core.
// Optional frame counter output out_frame is enabled by defining DIT_REORDER_FRAME_CNT_EN.
module dit_reorder #(
    parameter int N      = 8,
    parameter int LOG_N  = 3,
    parameter int X_WDTH = 16,
    parameter int MWIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*X_WDTH-1:0]   in_data,
    input  logic                  in_nd,
    input  logic [MWIDTH-1:0]     in_m,
    input  logic                  in_bypass,
    input  logic                  out_stall,
    output logic [2*X_WDTH-1:0]   out_data,
    output logic                  out_nd,
    output logic [MWIDTH-1:0]     out_m,
    output logic                  first,
    output logic                  error,
`ifdef DIT_REORDER_FRAME_CNT_EN
    output logic [15:0]           out_frame,
`endif
    output logic                  dbg_state
);

    // Strobe semantics: in_nd/out_nd mark a valid sample for one cycle; there is no
    // ready path upstream, so a frame that finds both banks full is dropped and flagged.
    localparam int DW = 2*X_WDTH + MWIDTH;

    typedef enum logic {S_IDLE, S_READ} state_t;

    logic [DW-1:0]       r_mem [0:2*N-1];
    logic [1:0]          r_byp;
    logic [1:0]          r_full;
    logic [LOG_N-1:0]    r_wr_cnt;
    logic [LOG_N-1:0]    r_rd_cnt;
    logic                r_wr_bank;
    logic                r_rd_bank;
    state_t              r_state;
    logic [2*X_WDTH-1:0] r_out_data;
    logic [MWIDTH-1:0]   r_out_m;
    logic                r_out_nd;
    logic                r_first;
    logic                r_error;

    logic                w_issue;
    logic                w_rd_last;
    logic                w_wr_full;
    logic                w_drop;
    logic                w_wr_en;
    logic                w_wr_last;
    logic [LOG_N-1:0]    w_rd_addr;
    logic [1:0]          w_full_nxt;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] k);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[LOG_N-1-i] = k[i];
        end
        return r;
    endfunction

    // The reader frees its bank before the writer's overflow check looks at it.
    assign w_issue   = r_full[r_rd_bank] && !out_stall;
    assign w_rd_last = w_issue && (r_rd_cnt == LOG_N'(N-1));
    assign w_wr_full = r_full[r_wr_bank] && !(w_rd_last && (r_rd_bank == r_wr_bank));
    assign w_drop    = in_nd && (r_wr_cnt == '0) && w_wr_full;
    assign w_wr_en   = in_nd && !w_drop;
    assign w_wr_last = w_wr_en && (r_wr_cnt == LOG_N'(N-1));
    assign w_rd_addr = r_byp[r_rd_bank] ? r_rd_cnt : bitrev(r_rd_cnt);

    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= {in_m, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp      <= '0;
            r_full     <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_state    <= S_IDLE;
            r_out_data <= '0;
            r_out_m    <= '0;
            r_out_nd   <= 1'b0;
            r_first    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_drop) r_error <= 1'b1;

            if (w_wr_en) begin
                if (r_wr_cnt == '0) r_byp[r_wr_bank] <= in_bypass;
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: if (w_full_nxt[r_rd_bank]) r_state <= S_READ;
                S_READ: if (w_rd_last && !w_full_nxt[~r_rd_bank]) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                {r_out_m, r_out_data} <= r_mem[{r_rd_bank, w_rd_addr}];
                r_out_nd <= 1'b1;
                r_first  <= (r_rd_cnt == '0);
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                end
            end else begin
                r_out_nd <= 1'b0;
                r_first  <= 1'b0;
            end
        end
    end

`ifdef DIT_REORDER_FRAME_CNT_EN
    logic        r_last_out;
    logic [15:0] r_frame;

    // Counts a frame on the cycle after its final sample appears on the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_out <= 1'b0;
            r_frame    <= '0;
        end else begin
            r_last_out <= w_rd_last;
            if (r_out_nd && r_last_out) r_frame <= r_frame + 16'd1;
        end
    end

    assign out_frame = r_frame;
`endif

    assign out_data  = r_out_data;
    assign out_m     = r_out_m;
    assign out_nd    = r_out_nd;
    assign first     = r_first;
    assign error     = r_error;
    assign dbg_state = r_state;

endmodule
